// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end for a shared ALU; grant counters under ALU_ARB_STATS_EN
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_ctrl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_ctrl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nxt;
    logic last, win0, win1, accept, rsp_take, id_q, zero_q;
    logic [3:0] ctrl_q;
    logic [31:0] a_q, b_q, res_q;
    // last holds the previous winner; a tie goes to the other requester
    always_comb begin
        win0 = req0_valid & (~req1_valid | last);
        win1 = req1_valid & (~req0_valid | ~last);
        accept = (state == IDLE) & (req0_valid | req1_valid);
        rsp_take = id_q ? rsp1_ready : rsp0_ready;
        state_nxt = state == IDLE ? (accept ? ISSUE : IDLE) :
                    state == ISSUE ? RESP :
                    (state == RESP && !rsp_take) ? RESP : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last <= 1'b1;
            id_q <= 1'b0;
            ctrl_q <= '0;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            zero_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ctrl_q <= win1 ? req1_ctrl : req0_ctrl;
                a_q <= win1 ? req1_a : req0_a;
                b_q <= win1 ? req1_b : req0_b;
                id_q <= win1;
                last <= win1;
            end
            if (state == ISSUE) begin
                res_q <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end
    assign req0_ready = (state == IDLE) & win0;
    assign req1_ready = (state == IDLE) & win1;
    assign alu_ctrl = (state == ISSUE) ? ctrl_q : 4'b0000;
    assign alu_a = (state == ISSUE) ? a_q : 32'd0;
    assign alu_b = (state == ISSUE) ? b_q : 32'd0;
    assign rsp0_valid = (state == RESP) & ~id_q;
    assign rsp1_valid = (state == RESP) & id_q;
    assign rsp_result = (state == RESP) ? res_q : 32'd0;
    assign rsp_zero = (state == RESP) & zero_q;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0, cnt1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (accept) begin
            if (!win1 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (win1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
        end
    end
    assign grant_cnt0 = cnt0;
    assign grant_cnt1 = cnt1;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU attached
module tb_alu_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0, rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [3:0] req0_ctrl = '0, req1_ctrl = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, alu_zero;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic [3:0] alu_ctrl;
    logic [15:0] grant_cnt0, grant_cnt1;
    int checks = 0, errors = 0;
    logic [15:0] exp_c0, exp_c1;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b0100: alu_result = alu_a << alu_b[4:0];
            4'b0101: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0110: alu_result = alu_a ^ alu_b;
            4'b0111: alu_result = alu_a >> alu_b[4:0];
            4'b1000: alu_result = {31'd0, alu_a < alu_b};
            4'b1111: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_rdy0"}, {31'd0, req0_ready}, 32'd0);
        chk({tag, "_rdy1"}, {31'd0, req1_ready}, 32'd0);
        chk({tag, "_rv0"}, {31'd0, rsp0_valid}, 32'd0);
        chk({tag, "_rv1"}, {31'd0, rsp1_valid}, 32'd0);
        chk({tag, "_res"}, rsp_result, 32'd0);
        chk({tag, "_zero"}, {31'd0, rsp_zero}, 32'd0);
        chk({tag, "_actrl"}, {28'd0, alu_ctrl}, 32'd0);
        chk({tag, "_aa"}, alu_a, 32'd0);
        chk({tag, "_ab"}, alu_b, 32'd0);
        chk({tag, "_cnt0"}, {16'd0, grant_cnt0}, 32'd0);
        chk({tag, "_cnt1"}, {16'd0, grant_cnt1}, 32'd0);
    endtask

    task automatic do_reset();
        {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
        rst_n = 1'b0;
        tick();
        tick();
        chk_idle_zero("reset");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_op(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic z);
        if (id) begin
            req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b;
        end
        #1;
        chk("op_rdy0", {31'd0, req0_ready}, {31'd0, ~id});
        chk("op_rdy1", {31'd0, req1_ready}, {31'd0, id});
        tick();
        {req0_valid, req1_valid} = '0;
        #1;
        chk("op_actrl", {28'd0, alu_ctrl}, {28'd0, c});
        chk("op_aa", alu_a, a);
        chk("op_ab", alu_b, b);
        chk("op_issue_rv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        tick();
        chk("op_rv", {30'd0, rsp1_valid, rsp0_valid}, id ? 32'd2 : 32'd1);
        chk("op_res", rsp_result, res);
        chk("op_zero", {31'd0, rsp_zero}, {31'd0, z});
        chk("op_resp_actrl", {28'd0, alu_ctrl}, 32'd0);
        if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        {rsp0_ready, rsp1_ready} = '0;
        #1;
        chk("op_done_rv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("op_done_res", rsp_result, 32'd0);
    endtask

    initial begin
        tick();
        do_reset();
        // single add 5+7
        do_op(1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);

        // tie straight after reset: requester 0 wins first
        do_reset();
        req0_valid = 1'b1; req0_ctrl = 4'b0001; req0_a = 32'd3; req0_b = 32'd3;
        req1_valid = 1'b1; req1_ctrl = 4'b0110; req1_a = 32'hF0; req1_b = 32'h0F;
        #1;
        chk("tie_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("tie_rdy1", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("tie_actrl0", {28'd0, alu_ctrl}, 32'd1);
        chk("tie_issue_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
        chk("tie_rv0", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
        chk("tie_res0", rsp_result, 32'd0);
        chk("tie_zero0", {31'd0, rsp_zero}, 32'd1);
        rsp1_ready = 1'b1;
        tick();
        chk("tie_foreign_ready", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        chk("tie2_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("tie2_rdy1", {31'd0, req1_ready}, 32'd1);
        tick();
        chk("tie_actrl1", {28'd0, alu_ctrl}, 32'd6);
        tick();
        chk("tie_rv1", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
        chk("tie_res1", rsp_result, 32'hFF);
        chk("tie_zero1", {31'd0, rsp_zero}, 32'd0);
        tick();
        rsp1_ready = 1'b0;

        // fairness with both held valid
        req0_ctrl = 4'b0000; req0_a = 32'd10; req0_b = 32'd20;
        req1_ctrl = 4'b0011; req1_a = 32'h0F; req1_b = 32'hF0;
        {rsp0_ready, rsp1_ready} = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fair_rdy0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("fair_rdy1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            tick();
            chk("fair_rv", {30'd0, rsp1_valid, rsp0_valid}, (i % 2 == 1) ? 32'd2 : 32'd1);
            chk("fair_res", rsp_result, (i % 2 == 1) ? 32'hFF : 32'd30);
            tick();
        end
        {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;

        // backpressure on requester 1
        req1_valid = 1'b1; req1_ctrl = 4'b1000; req1_a = 32'd1; req1_b = 32'd2;
        #1;
        chk("bp_rdy1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rv1", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
            chk("bp_res", rsp_result, 32'd1);
            chk("bp_rdy0", {31'd0, req0_ready}, 32'd0);
            tick();
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_rdy0_last", {31'd0, req0_ready}, 32'd0);
        tick();
        rsp1_ready = 1'b0;
        #1;
        chk("bp_resume_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("bp_resume_rv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("bp_after_res", rsp_result, 32'd30);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // grant counters
        do_reset();
        do_op(1'b0, 4'b0010, 32'hFF, 32'h0F, 32'h0F, 1'b0);
        do_op(1'b1, 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        do_op(1'b0, 4'b0100, 32'd1, 32'd4, 32'h10, 1'b0);
        do_op(1'b1, 4'b1111, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
        do_op(1'b0, 4'b0111, 32'h80, 32'd3, 32'h10, 1'b0);
`ifdef ALU_ARB_STATS_EN
        exp_c0 = 16'd3; exp_c1 = 16'd2;
`else
        exp_c0 = 16'd0; exp_c1 = 16'd0;
`endif
        chk("cnt0", {16'd0, grant_cnt0}, {16'd0, exp_c0});
        chk("cnt1", {16'd0, grant_cnt1}, {16'd0, exp_c1});

        // reset while in ISSUE drops the operation
        req0_valid = 1'b1; req0_ctrl = 4'b0000; req0_a = 32'd1; req0_b = 32'd1;
        tick();
        req0_valid = 1'b0;
        #1;
        chk("mid_issue_aa", alu_a, 32'd1);
        rst_n = 1'b0;
        tick();
        chk_idle_zero("mid_reset");
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("mid_no_res", rsp_result, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
